// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin UART transmitter: 8N1-style frames paced by an external baud_tick.
// Optional even parity bit after the data bits when UART_TX_ARBITER_PARITY_EN is defined.
module uart_tx_arbiter #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_tick,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
`ifdef UART_TX_ARBITER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic              last_winner;
`ifdef UART_TX_ARBITER_PARITY_EN
    logic              par;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            txd         <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            last_winner <= 1'b1;
            sr          <= '0;
            cnt         <= '0;
`ifdef UART_TX_ARBITER_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                // A tick on the grant edge is lost by construction: we are still in IDLE.
                IDLE: begin
                    if (req0 || req1) begin
                        if (req0 && (!req1 || last_winner)) begin
                            gnt0        <= 1'b1;
                            sr          <= data0;
                            last_winner <= 1'b0;
`ifdef UART_TX_ARBITER_PARITY_EN
                            par         <= ^data0;
`endif
                        end else begin
                            gnt1        <= 1'b1;
                            sr          <= data1;
                            last_winner <= 1'b1;
`ifdef UART_TX_ARBITER_PARITY_EN
                            par         <= ^data1;
`endif
                        end
                        busy  <= 1'b1;
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (baud_tick) begin
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        txd   <= sr[0];
                        sr    <= sr >> 1;
                        cnt   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (cnt == BIT_LAST) begin
                            cnt   <= '0;
`ifdef UART_TX_ARBITER_PARITY_EN
                            txd   <= par;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            txd <= sr[0];
                            sr  <= sr >> 1;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_ARBITER_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                // The bit counter is reused to count stop periods.
                STOP: begin
                    if (baud_tick) begin
                        if (cnt == STOP_LAST) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
